// File: rtl/ps2_tx.sv
`timescale 1ns/1ps
// ps2_tx: PS/2 host-to-device transmitter. Inhibits the bus, sends start/data/parity/stop
// on device clock edges, checks the device ACK and reports ack/err with a done pulse.

module ps2_tx_filter #(
  parameter int unsigned FILTER = 8
) (
  input  logic clock,
  input  logic reset_n,
  input  logic pin,
  output logic level
);
  localparam int unsigned CW = $clog2(FILTER + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER - 1);

  logic          meta;
  logic          sync;
  logic [CW-1:0] cnt;

  // NOTE: the synchronizer and filter reset to 1, the idle level of the pulled-up bus,
  // so leaving reset never produces a phantom falling edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta  <= 1'b1;
      sync  <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
    end else begin
      meta <= pin;
      sync <= meta;
      if (sync == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

module ps2_tx #(
  parameter int unsigned CLK_HZ  = 25_000_000,
  parameter int unsigned INHIBIT = 2500,
  parameter int unsigned TIMEOUT = 375_000,
  parameter int unsigned FILTER  = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ps_clk_i,
  input  logic       ps_dat_i,
  output logic       ps_clk_oe,
  output logic       ps_dat_oe,
  input  logic [7:0] data,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       ack,
  output logic       err
);
  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_START,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  localparam int unsigned IW = $clog2(INHIBIT + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  if (CLK_HZ == 0 || INHIBIT == 0 || TIMEOUT < 2 || FILTER == 0) begin : g_bad_params
    $error("ps2_tx: CLK_HZ, INHIBIT, FILTER must be nonzero and TIMEOUT at least 2");
  end

  logic clk_lvl;
  logic dat_lvl;
  logic clk_lvl_q;
  logic fall;

  ps2_tx_filter #(.FILTER(FILTER)) u_clk_filter (
    .clock   (clock),
    .reset_n (reset_n),
    .pin     (ps_clk_i),
    .level   (clk_lvl)
  );

  ps2_tx_filter #(.FILTER(FILTER)) u_dat_filter (
    .clock   (clock),
    .reset_n (reset_n),
    .pin     (ps_dat_i),
    .level   (dat_lvl)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) clk_lvl_q <= 1'b1;
    else          clk_lvl_q <= clk_lvl;
  end

  assign fall = clk_lvl_q & ~clk_lvl;

  state_t        state;
  logic [9:0]    shreg;
  logic [3:0]    bit_cnt;
  logic [IW-1:0] inh_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          ack_seen;

  // NOTE: all state and outputs use non-blocking assignments so every branch sees the
  // values from before this edge, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      inh_cnt   <= '0;
      tmo_cnt   <= '0;
      ack_seen  <= 1'b0;
      ps_clk_oe <= 1'b0;
      ps_dat_oe <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ack       <= 1'b0;
      err       <= 1'b0;
    end else begin
      // NOTE: done defaults low every cycle so any branch that sets it yields one pulse.
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            shreg     <= {1'b1, ~^data, data};
            ack       <= 1'b0;
            err       <= 1'b0;
            ack_seen  <= 1'b0;
            busy      <= 1'b1;
            ps_clk_oe <= 1'b1;
            inh_cnt   <= '0;
            state     <= S_INHIBIT;
          end
        end

        S_INHIBIT: begin
          if (inh_cnt == INH_LAST) begin
            ps_dat_oe <= 1'b1;
            state     <= S_START;
          end else begin
            inh_cnt <= inh_cnt + IW'(1);
          end
        end

        S_START: begin
          ps_clk_oe <= 1'b0;
          bit_cnt   <= '0;
          tmo_cnt   <= '0;
          state     <= S_SEND;
        end

        S_SEND, S_ACK, S_WAIT_IDLE: begin
          if (!fall && tmo_cnt == TMO_LAST) begin
            ps_dat_oe <= 1'b0;
            ack       <= 1'b0;
            err       <= 1'b1;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end else begin
            tmo_cnt <= fall ? '0 : tmo_cnt + TW'(1);
            if (state == S_SEND && fall) begin
              // Bits leave LSB first; the trailing stop bit 1 releases the data line.
              ps_dat_oe <= ~shreg[0];
              shreg     <= {1'b0, shreg[9:1]};
              bit_cnt   <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd9) state <= S_ACK;
            end else if (state == S_ACK && fall) begin
              ack_seen <= ~dat_lvl;
              state    <= S_WAIT_IDLE;
            end else if (state == S_WAIT_IDLE && clk_lvl && dat_lvl) begin
              ack   <= ack_seen;
              err   <= ~ack_seen;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
        end

        default: begin
          ps_clk_oe <= 1'b0;
          ps_dat_oe <= 1'b0;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ps2_tx.sv
`timescale 1ns/1ps
// tb_ps2_tx: drives ps2_tx against a behavioural PS/2 device, checking frames, handshake
// timing, ack/err reporting, timeout and reset behaviour.

module tb_ps2_tx;
  localparam int INHIBIT = 100;
  localparam int TIMEOUT = 1500;
  localparam int FILTER  = 8;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] data    = 8'h00;
  logic       start   = 1'b0;
  logic       ps_clk_oe, ps_dat_oe, busy, done, ack, err;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       pin_clk, pin_dat;

  assign pin_clk = ~(ps_clk_oe | dev_clk_low);
  assign pin_dat = ~(ps_dat_oe | dev_dat_low);

  ps2_tx #(
    .CLK_HZ  (25_000_000),
    .INHIBIT (INHIBIT),
    .TIMEOUT (TIMEOUT),
    .FILTER  (FILTER)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .ps_clk_i  (pin_clk),
    .ps_dat_i  (pin_dat),
    .ps_clk_oe (ps_clk_oe),
    .ps_dat_oe (ps_dat_oe),
    .data      (data),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .ack       (ack),
    .err       (err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  initial forever begin
    @(posedge clock);
    cyc++;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
  endtask

  task automatic check_range(input string name, input longint actual, input longint lo,
                             input longint hi);
    n_checks++;
    if (actual >= lo && actual <= hi) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, actual, lo, hi, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Frame in transmission order: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] make_frame(input logic [7:0] d);
    int ones = 0;
    logic [10:0] f;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    f[0]   = 1'b0;
    f[8:1] = d;
    f[9]   = (ones % 2 == 0);
    f[10]  = 1'b1;
    return f;
  endfunction

  // Transaction model: expected outputs follow from the accepted start cycle and the
  // outcome the device scenario is set up to produce.
  bit active   = 1'b0;
  int t_start  = 0;
  bit exp_ack  = 1'b0;
  bit exp_err  = 1'b0;
  bit held_ack = 1'b0;
  bit held_err = 1'b0;
  int n_done   = 0;
  int done_cyc = 0;
  logic got[$];

  initial forever begin
    @(negedge clock);
    if (reset_n) begin
      if (active && cyc >= t_start + 1) begin
        check("clk_oe", ps_clk_oe, cyc <= t_start + 1 + INHIBIT);
        if (cyc <= t_start + 1 + INHIBIT)
          check("dat_oe_pre_release", ps_dat_oe, cyc == t_start + 1 + INHIBIT);
        if (done) begin
          check("busy_at_done", busy, 0);
          check("ack_at_done", ack, exp_ack);
          check("err_at_done", err, exp_err);
          held_ack = exp_ack;
          held_err = exp_err;
          n_done++;
          done_cyc = cyc;
          active   = 1'b0;
        end else begin
          check("busy_active", busy, 1);
          check("ack_cleared", ack, 0);
          check("err_cleared", err, 0);
        end
      end else if (!active) begin
        check("idle_done", done, 0);
        check("idle_busy", busy, 0);
        check("idle_clk_oe", ps_clk_oe, 0);
        check("idle_dat_oe", ps_dat_oe, 0);
        check("idle_ack_held", ack, held_ack);
        check("idle_err_held", err, held_err);
      end
    end
  end

  task automatic send_start(input logic [7:0] d);
    tick(1);
    data    = d;
    start   = 1'b1;
    t_start = cyc;
    active  = 1'b1;
    tick(1);
    start = 1'b0;
    data  = 8'($urandom_range(0, 255));
  endtask

  // One host request answered by the device model. pulses < 11 means the device stops
  // clocking early; glitch adds a 3-cycle spike before the 4th fall; poke re-pulses start.
  task automatic run_txn(input logic [7:0] d, input bit do_ack, input int pulses,
                         input int half, input bit glitch, input bit poke,
                         output logic [10:0] got_vec);
    logic [10:0] frame = make_frame(d);
    logic [10:0] mask  = '0;
    int n0 = n_done;
    int last_fall = 0;
    bit rts = 1'b0;
    exp_ack = do_ack && pulses == 11;
    exp_err = !exp_ack;
    got.delete();
    send_start(d);
    for (int i = 0; i < INHIBIT + 20; i++) begin
      if (pin_clk && !pin_dat) begin
        rts = 1'b1;
        break;
      end
      tick(1);
    end
    check("request_to_send_seen", rts, 1);
    if (rts) begin
      got.push_back(pin_dat);
      for (int p = 1; p <= pulses; p++) begin
        if (glitch && p == 4) begin
          tick(10);
          dev_clk_low = 1'b1;
          tick(3);
          dev_clk_low = 1'b0;
          tick(half - 13);
        end else begin
          tick(half);
        end
        dev_clk_low = 1'b1;
        last_fall   = cyc;
        if (poke && p == 2) begin
          data  = 8'h55;
          start = 1'b1;
          tick(1);
          start = 1'b0;
          tick(half - 1);
        end else begin
          tick(half);
        end
        dev_clk_low = 1'b0;
        if (p <= 10) got.push_back(pin_dat);
        if (p == 10 && do_ack) dev_dat_low = 1'b1;
        if (p == 11) dev_dat_low = 1'b0;
      end
    end
    for (int i = 0; i < TIMEOUT + 300 && n_done == n0; i++) tick(1);
    check("done_seen", n_done - n0, 1);
    if (pulses < 11 && n_done != n0)
      check_range("timeout_latency", done_cyc - last_fall, TIMEOUT, TIMEOUT + FILTER + 4);
    got_vec = '0;
    foreach (got[i]) begin
      got_vec[i] = got[i];
      mask[i]    = 1'b1;
    end
    check("frame_bits", got_vec, frame & mask);
    tick(20);
    check("single_done", n_done - n0, 1);
  endtask

  initial begin
    #(900_000 * 10);
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [10:0] fv;
    tick(3);
    check("reset_clk_oe", ps_clk_oe, 0);
    check("reset_dat_oe", ps_dat_oe, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_ack", ack, 0);
    check("reset_err", err, 0);
    reset_n = 1'b1;
    tick(20);

    // Reset in the middle of the inhibit period releases the lines without a clock edge.
    send_start(8'hA5);
    tick(30);
    check("inhibit_clk_oe_before_reset", ps_clk_oe, 1);
    #3;
    reset_n = 1'b0;
    active  = 1'b0;
    held_ack = 1'b0;
    held_err = 1'b0;
    #1;
    check("async_reset_clk_oe", ps_clk_oe, 0);
    check("async_reset_dat_oe", ps_dat_oe, 0);
    check("async_reset_busy", busy, 0);
    tick(2);
    reset_n = 1'b1;
    tick(20);

    run_txn(8'hED, 1'b1, 11, 40, 1'b0, 1'b0, fv);
    check("ed_frame_literal", fv, 11'h7DA);
    check("ed_ack_literal", ack, 1);
    check("ed_err_literal", err, 0);

    run_txn(8'h01, 1'b1, 11, 40, 1'b0, 1'b0, fv);
    check("parity_01_literal", fv[9], 0);
    run_txn(8'hFF, 1'b1, 11, 40, 1'b0, 1'b0, fv);
    check("parity_ff_literal", fv[9], 1);
    run_txn(8'h00, 1'b1, 11, 40, 1'b0, 1'b0, fv);
    check("parity_00_literal", fv[9], 1);

    run_txn(8'h3C, 1'b0, 11, 40, 1'b0, 1'b0, fv);
    check("noack_ack_literal", ack, 0);
    check("noack_err_literal", err, 1);

    run_txn(8'hC3, 1'b1, 4, 40, 1'b0, 1'b0, fv);
    check("timeout_err_literal", err, 1);
    check("timeout_clk_oe", ps_clk_oe, 0);
    check("timeout_dat_oe", ps_dat_oe, 0);

    run_txn(8'h96, 1'b1, 11, 40, 1'b0, 1'b1, fv);
    check("busy_start_frame_literal", fv, {1'b1, 1'b1, 8'h96, 1'b0});
    run_txn(8'h5A, 1'b1, 11, 40, 1'b1, 1'b0, fv);
    check("glitch_frame_literal", fv, {1'b1, 1'b1, 8'h5A, 1'b0});

    for (int k = 0; k < 12; k++) begin
      run_txn(8'($urandom_range(0, 255)), $urandom_range(0, 7) != 0, 11,
              $urandom_range(25, 60), 1'b0, 1'b0, fv);
    end

    tick(10);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
